// File: rtl/reg_file_spill_if.sv
// Stream/control bundle between reg_file_spill and the memory controller.
// Carries spill/fill start requests, status, and both valid/ready streams.
interface reg_file_spill_if #(
    parameter int DW = 8,
    parameter int PW = 4
);
    logic          spillStart;
    logic          fillStart;
    logic          busy;
    logic          done;
    logic [DW-1:0] spillData;
    logic [PW-1:0] spillIdx;
    logic          spillValid;
    logic          spillReady;
    logic [DW-1:0] fillData;
    logic          fillValid;
    logic          fillReady;

    modport master (
        output spillStart, fillStart, spillReady, fillData, fillValid,
        input  busy, done, spillData, spillIdx, spillValid, fillReady
    );

    modport slave (
        input  spillStart, fillStart, spillReady, fillData, fillValid,
        output busy, done, spillData, spillIdx, spillValid, fillReady
    );
endinterface

// File: rtl/reg_file_spill.sv
// Accumulator-style register file with spill/fill streaming.
// r0 is the accumulator; r1..rNREG-1 are general registers. Spill streams
// r0..rNREG-1 out over valid/ready, fill streams them back in.
// Optional feature: define REGFILE_SWAP_EN to add the regSwap port
// (r0 <-> r[opRegAddr] in one cycle).
//
// state | meaning
// IDLE  | accepts single-cycle ops and spill/fill starts
// SPILL | streaming r[idx] out, ops dropped
// FILL  | streaming fillData into r[idx], ops dropped
module reg_file_spill #(
    parameter int DW = 8,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          regWrite,
    input  logic          regGet,
    input  logic          regSet,
`ifdef REGFILE_SWAP_EN
    input  logic          regSwap,
`endif
    input  logic [DW-1:0] writeData,
    input  logic [PW-1:0] opRegAddr,
    output logic [DW-1:0] accData,
    output logic [DW-1:0] opRegData,
    reg_file_spill_if.slave bus
);

    localparam int NREG = 2 ** PW;
    localparam logic [PW-1:0] LAST = PW'(NREG - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPILL = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] idx_q, idx_d;
    logic          done_q;
    logic          beat;
    logic          last_beat;
    logic          addr_nz;
    logic [DW-1:0] regs [NREG];

    assign addr_nz = (opRegAddr != '0);

    // State, beat index and the one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= last_beat;
        end
    end

    // Next state: start decode in IDLE, beat counting while streaming.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        beat      = 1'b0;
        last_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.spillStart)
                    state_d = SPILL;
                else if (bus.fillStart)
                    state_d = FILL;
            end
            SPILL:   beat = bus.spillReady;
            FILL:    beat = bus.fillValid;
            default: state_d = IDLE;
        endcase
        if (beat) begin
            if (idx_q == LAST) begin
                idx_d     = '0;
                state_d   = IDLE;
                last_beat = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Register array: fill beats while streaming, prioritised ops in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (state_q == FILL) begin
            if (bus.fillValid)
                regs[idx_q] <= bus.fillData;
        end else if (state_q == IDLE) begin
            // A selected op with address 0 still wins priority; it just does nothing.
            if (regWrite) begin
                regs[0] <= writeData;
            end else if (regGet) begin
                if (addr_nz)
                    regs[0] <= regs[opRegAddr];
`ifdef REGFILE_SWAP_EN
            end else if (regSwap) begin
                if (addr_nz) begin
                    regs[0]         <= regs[opRegAddr];
                    regs[opRegAddr] <= regs[0];
                end
`endif
            end else if (regSet) begin
                if (addr_nz)
                    regs[opRegAddr] <= regs[0];
            end
        end
    end

    assign accData        = regs[0];
    assign opRegData      = regs[opRegAddr];
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.spillValid = (state_q == SPILL);
    assign bus.fillReady  = (state_q == FILL);
    assign bus.spillData  = regs[idx_q];
    assign bus.spillIdx   = idx_q;

endmodule

// File: tb/tb_reg_file_spill.sv
// Self-checking bench for reg_file_spill: a spec-level model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_reg_file_spill;

    logic       clk;
    logic       reset;
    logic       regWrite, regGet, regSet;
    logic       regSwap;
    logic [7:0] writeData;
    logic [3:0] opRegAddr;
    logic [7:0] accData, opRegData;

    reg_file_spill_if #(.DW(8), .PW(4)) bus ();

    reg_file_spill #(.DW(8), .PW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .regWrite  (regWrite),
        .regGet    (regGet),
        .regSet    (regSet),
`ifdef REGFILE_SWAP_EN
        .regSwap   (regSwap),
`endif
        .writeData (writeData),
        .opRegAddr (opRegAddr),
        .accData   (accData),
        .opRegData (opRegData),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    logic [7:0] m_regs [16];
    int         m_mode;   // 0 idle, 1 spill, 2 fill
    int         m_idx;
    bit         m_done;
    logic [7:0] m_tmp;

    task automatic m_advance();
        if (m_idx == 15) begin
            m_idx  = 0;
            m_mode = 0;
            m_done = 1'b1;
        end else begin
            m_idx = m_idx + 1;
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
            m_mode = 0;
            m_idx  = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_mode == 0) begin
                if (regWrite) m_regs[0] = writeData;
                else if (regGet) begin
                    if (opRegAddr != 0) m_regs[0] = m_regs[opRegAddr];
                end
`ifdef REGFILE_SWAP_EN
                else if (regSwap) begin
                    if (opRegAddr != 0) begin
                        m_tmp = m_regs[0];
                        m_regs[0] = m_regs[opRegAddr];
                        m_regs[opRegAddr] = m_tmp;
                    end
                end
`endif
                else if (regSet) begin
                    if (opRegAddr != 0) m_regs[opRegAddr] = m_regs[0];
                end
                if (bus.spillStart) m_mode = 1;
                else if (bus.fillStart) m_mode = 2;
            end else if (m_mode == 1) begin
                if (bus.spillReady) m_advance();
            end else begin
                if (bus.fillValid) begin
                    m_regs[m_idx] = bus.fillData;
                    m_advance();
                end
            end
        end
    end

    // ---------------- per-cycle compare + scoreboard ----------------
    logic [7:0] spilled [$];
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("accData", accData, m_regs[0]);
            check("opRegData", opRegData, m_regs[opRegAddr]);
            check("busy", bus.busy, m_mode != 0);
            check("done", bus.done, m_done);
            check("spillValid", bus.spillValid, m_mode == 1);
            check("fillReady", bus.fillReady, m_mode == 2);
            check("spillIdx", bus.spillIdx, m_idx[3:0]);
            if (m_mode == 1) check("spillData", bus.spillData, m_regs[m_idx]);
            if (bus.spillValid && bus.spillReady) spilled.push_back(bus.spillData);
            if (bus.done) done_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int fed;
    int cyc;

    initial begin
        reset = 1'b1; regWrite = 0; regGet = 0; regSet = 0; regSwap = 0;
        writeData = 0; opRegAddr = 0;
        bus.spillStart = 0; bus.fillStart = 0; bus.spillReady = 0;
        bus.fillData = 0; bus.fillValid = 0;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_acc", accData, 8'h00);
        check("reset_busy", bus.busy, 1'b0);

        // write / set / get
        regWrite = 1; writeData = 8'h5A; tick(); regWrite = 0;
        regSet = 1; opRegAddr = 3; tick(); regSet = 0;
        check("set_r3", opRegData, 8'h5A);
        check("set_acc", accData, 8'h5A);
        regWrite = 1; writeData = 8'h11; tick(); regWrite = 0;
        check("write_acc", accData, 8'h11);
        regGet = 1; opRegAddr = 3; tick();
        check("get_r3", accData, 8'h5A);
        opRegAddr = 0; tick(); regGet = 0;
        check("get_r0_noop", accData, 8'h5A);

        // priority: regWrite beats regSet in the same cycle
        regWrite = 1; regSet = 1; writeData = 8'h77; opRegAddr = 3; tick();
        regWrite = 0; regSet = 0; #1;
        check("prio_r3_kept", opRegData, 8'h5A);

        // load r[i] = i*3
        for (int i = 1; i < 16; i++) begin
            regWrite = 1; writeData = 8'(i * 3); tick(); regWrite = 0;
            regSet = 1; opRegAddr = 4'(i); tick(); regSet = 0;
        end
        regWrite = 1; writeData = 8'h00; tick(); regWrite = 0;

        // spill with toggling ready
        spilled.delete();
        bus.spillStart = 1; tick(); bus.spillStart = 0;
        cyc = 0;
        while (done_cnt == 0 && cyc < 100) begin
            bus.spillReady = ~bus.spillReady;
            tick();
            cyc++;
        end
        bus.spillReady = 0;
        if (cyc >= 100) check("spill_timeout", 1, 0);
        tick(); tick();
        check("spill_beats", spilled.size(), 16);
        for (int i = 0; i < 16 && i < spilled.size(); i++)
            check("spill_order", spilled[i], 8'(i * 3));
        check("spill_done_once", done_cnt, 1);

        // fill with gaps; regWrite attempted while busy
        bus.fillStart = 1; tick(); bus.fillStart = 0;
        fed = 0; cyc = 0;
        while (fed < 16 && cyc < 200) begin
            bus.fillValid = (cyc % 3 != 1);
            bus.fillData  = 8'(8'hF0 + fed);
            regWrite = (cyc == 5); writeData = 8'hAA;
            tick();
            if (bus.fillValid) fed++;
            cyc++;
        end
        bus.fillValid = 0; regWrite = 0;
        if (cyc >= 200) check("fill_timeout", 1, 0);
        tick(); tick();
        check("fill_done", done_cnt, 2);
        check("fill_busy_drop", accData, 8'hF0);
        for (int i = 0; i < 16; i++) begin
            opRegAddr = 4'(i); #1;
            check("fill_reg", opRegData, 8'(8'hF0 + i));
        end

        // reset mid-spill at beat 7
        bus.spillStart = 1; tick(); bus.spillStart = 0;
        bus.spillReady = 1;
        for (int i = 0; i < 7; i++) tick();
        check("pre_reset_idx", bus.spillIdx, 4'd7);
        reset = 1; tick(); reset = 0; bus.spillReady = 0;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_acc", accData, 8'h00);
        for (int i = 0; i < 16; i++) begin
            opRegAddr = 4'(i); #1;
            check("rst_reg", opRegData, 8'h00);
        end
        tick(); tick(); tick();
        check("rst_no_done", done_cnt, 2);

        // both starts together -> SPILL
        bus.spillStart = 1; bus.fillStart = 1; tick();
        bus.spillStart = 0; bus.fillStart = 0;
        check("both_spill", bus.spillValid, 1'b1);
        check("both_not_fill", bus.fillReady, 1'b0);
        bus.spillReady = 1;
        cyc = 0;
        while (done_cnt == 2 && cyc < 50) begin tick(); cyc++; end
        bus.spillReady = 0;
        if (cyc >= 50) check("both_timeout", 1, 0);
        tick();
        check("both_done", done_cnt, 3);

`ifdef REGFILE_SWAP_EN
        regWrite = 1; writeData = 8'h02; tick(); regWrite = 0;
        regSet = 1; opRegAddr = 5; tick(); regSet = 0;
        regWrite = 1; writeData = 8'h01; tick(); regWrite = 0;
        regSwap = 1; opRegAddr = 5; tick(); regSwap = 0;
        check("swap_acc", accData, 8'h02);
        check("swap_r5", opRegData, 8'h01);
`endif

        tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
